seq_event_counter: RTL
======================

Name: seq_event_counter

Overview:
- Downstream consumer of the "111" sequence detector's out_bit, which is a level: it stays high while the FSM remains in state D.
- Converts each assertion of that level into exactly one event. Counts events in a wrapping or saturating counter.
- Drives a 7-segment display of the count's low nibble, with an overflow decimal point, plus a stretched LED flash per event.
- Sits in top between the detector and SEG/LED.

Parameters:
- NBITS_CNT, 8: event counter width.
- SATURATE, 0: 0 = counter wraps at max to 0; 1 = counter holds at max.
- STRETCH, 4: cycles led_evt stays high per event (≥1).

Ports:
- clk_2  input  1  system clock (divided clock).
- reset  input  1  asynchronous, active-low reset.
- det_in  input  1  detector out_bit (level).
- clear  input  1  synchronous clear of count, ovf and display, active-high.
- hold  input  1  freezes the display register; counting continues.
- count  output  NBITS_CNT  live event count.
- ovf  output  1  sticky: set when count passes max (wrap or saturate attempt).
- event_pulse  output  1  registered one-cycle pulse per counted event.
- led_evt  output  1  stretched event flash.
- seg  output  8  7-segment pattern: seg[0]=a … seg[6]=g, seg[7]=dp; active-high.

Behaviour:
- Reset (reset=0, asynchronous):
  - det_q=1, so det_in must be seen low before any event is counted; a level that is still high across reset release is not counted.
  - count=0, ovf=0, disp_q=0, event_pulse=0, led_evt=0, stretch counter=0, FSM=IDLE.
- Edge detect:
  - det_q <= det_in every edge.
  - rise = det_in & ~det_q.
  - Only a 0→1 transition counts; long high runs count once.
- Count, at the edge where rise=1 and clear=0:
  - Normal case: count <= count+1.
  - At max with SATURATE=0: count <= 0, ovf <= 1.
  - At max with SATURATE=1: count stays at max, ovf <= 1.
  - Latency: count updates at the same edge rise is sampled; event_pulse is high for the following cycle only.
- clear=1 has priority over rise in the same cycle:
  - count, ovf and disp_q go to 0.
  - event_pulse <= 0.
  - det_q still updates; the event is lost.
  - The stretcher is not affected.
- Display register:
  - disp_q <= hold ? disp_q : count_next, where count_next is the value count takes at this edge.
  - With hold=0, seg reflects the new count in the same cycle count changes.
  - Releasing hold reloads disp_q on the next edge.
- seg decode is combinational from disp_q[3:0], hex 0..F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- seg[7] = ovf.
- Stretcher FSM, state IDLE/FLASH, 0-based counter scnt:
  - IDLE: on counted event → FLASH, scnt <= 0.
  - FLASH: scnt increments; at scnt==STRETCH-1 → IDLE.
  - A new event in FLASH restarts scnt at 0 (retrigger).
  - led_evt = (state==FLASH), registered. It rises in the same cycle as event_pulse and lasts STRETCH cycles after the last event.
- Mid-operation reset: all state returns to the reset values immediately, without waiting for the clock.
- All outputs are glitch-free registers except seg, which is decoded from registers only.

Test Plan:
- Reset release with det_in=1 held → no event. Then det_in 0 for 1 cycle, back to 1 → count=1, event_pulse one cycle, seg=0x06.
- det_in high for 20 cycles → count increments by exactly 1. led_evt high exactly 4 cycles (STRETCH=4).
- 255 events with SATURATE=0 → count=0xFF, seg=0x71, ovf=0. One more event → count=0, ovf=1, seg=0xBF. With SATURATE=1: count stays 0xFF, ovf=1, seg=0xF1.
- hold=1 at count=3, then 2 events → count=5, seg stays 0x4F. Drop hold → seg=0x6D next cycle.
- clear=1 in the same cycle as rise at count=7 → count=0, ovf=0, seg=0x3F, no event_pulse.
- Two events 2 cycles apart (STRETCH=4) → led_evt continuously high 6 cycles. Assert reset mid-flash → led_evt=0 and count=0 immediately, without a clock edge.

Source files
------------

// File: rtl/seq_event_counter.sv
// seq_event_counter: counts rising edges of the sequence detector level and drives SEG/LED.
module seq_event_counter #(
  parameter int NBITS_CNT = 8,
  parameter bit SATURATE  = 1'b0,
  parameter int STRETCH   = 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 det_in,
  input  logic                 clear,
  input  logic                 hold,
  output logic [NBITS_CNT-1:0] count,
  output logic                 ovf,
  output logic                 event_pulse,
  output logic                 led_evt,
  output logic [7:0]           seg
);
  localparam int SW = $clog2(STRETCH + 1);
  localparam logic [NBITS_CNT-1:0] MAX = '1;
  localparam logic [15:0][6:0] SEG_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic {IDLE, FLASH} state_t;
  state_t state, state_n;
  logic [SW-1:0] scnt, scnt_n;
  logic det_q, evt, at_max;
  logic [NBITS_CNT-1:0] count_next;
  logic [3:0] disp_q;
  assign evt = det_in & ~det_q & ~clear;
  assign at_max = count == MAX;
  assign count_next = clear ? '0 : !evt ? count : !at_max ? count + NBITS_CNT'(1) : SATURATE ? MAX : '0;
  // det_q resets high so a level already present at reset release is not an event
  always_ff @(posedge clk_2 or negedge reset)
    if (!reset) begin
      det_q       <= 1'b1;
      count       <= '0;
      ovf         <= 1'b0;
      disp_q      <= '0;
      event_pulse <= 1'b0;
    end else begin
      det_q       <= det_in;
      count       <= count_next;
      ovf         <= !clear & (ovf | (evt & at_max));
      disp_q      <= clear ? '0 : hold ? disp_q : count_next[3:0];
      event_pulse <= evt;
    end
  always_ff @(posedge clk_2 or negedge reset)
    if (!reset) begin
      state <= IDLE;
      scnt  <= '0;
    end else begin
      state <= state_n;
      scnt  <= scnt_n;
    end
  // a new event retriggers the flash from zero
  always_comb begin
    state_n = evt ? FLASH : (state == FLASH && scnt == SW'(STRETCH - 1)) ? IDLE : state;
    scnt_n  = evt ? '0 : state == FLASH ? scnt + SW'(1) : scnt;
  end
  assign led_evt = state == FLASH;
  assign seg = {ovf, SEG_LUT[disp_q]};
endmodule
